// File: rtl/flit_rx_monitor.sv
// Receive-side monitor for the adder characterization link: checks packet framing
// and the data-pattern sequence, and accumulates toggle/utilization statistics.
module flit_rx_monitor #(
  parameter int N       = 9,
  parameter int PAYLOAD = 20,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flit_valid,
  input  logic [N-1:0]     input1,
  input  logic [N-1:0]     input2,
  output logic             pkt_done,
  output logic             len_err,
  output logic             seq_err,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] flit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] short_count,
  output logic [CNT_W-1:0] toggle_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int  W        = 2 * N;
  localparam int  BEAT_W   = $clog2(PAYLOAD + 1);
  localparam int  PC_W     = $clog2(W + 1);
  localparam bit  CHECK_EN = (W == 18);

  typedef enum logic {IDLE, RECV} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, cur_beat;
  logic [3:0]          pat_q, pat_d, cur_pat;
  logic [W-1:0]        prev_link_q, link;
  logic                pkt_done_q, pkt_done_d;
  logic                len_err_q, len_err_d;
  logic                seq_err_q, seq_err_d;
  logic                accept;
  logic [CNT_W-1:0]    pkt_cnt_q, flit_cnt_q, err_cnt_q, short_cnt_q, tog_cnt_q, cyc_cnt_q;

  function automatic logic [17:0] pattern(input logic [3:0] idx);
    case (idx)
      4'd0:    return 18'h3FC00;
      4'd1:    return 18'h3FFFC;
      4'd2:    return 18'h00FFF;
      4'd3:    return 18'h0000F;
      4'd4:    return 18'h3C000;
      4'd5:    return 18'h3FFC0;
      4'd6:    return 18'h0FFFF;
      4'd7:    return 18'h000FF;
      default: return 18'h00000;
    endcase
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] x);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + PC_W'(x[i]);
    return c;
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign link = {input2, input1};

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    beat_d     = beat_q;
    pat_d      = pat_q;
    pkt_done_d = 1'b0;
    len_err_d  = 1'b0;
    seq_err_d  = 1'b0;
    accept     = flit_valid;
    // A flit arriving in IDLE is always beat 0 of a new packet.
    cur_beat   = (state_q == IDLE) ? '0 : beat_q;
    cur_pat    = (state_q == IDLE) ? '0 : pat_q;

    if (accept) begin
      seq_err_d = CHECK_EN && (link != W'(pattern(cur_pat)));
      if (cur_beat == BEAT_W'(PAYLOAD - 1)) begin
        pkt_done_d = 1'b1;
        state_d    = IDLE;
        beat_d     = '0;
        pat_d      = '0;
      end else begin
        state_d = RECV;
        beat_d  = cur_beat + BEAT_W'(1);
        pat_d   = (cur_pat == 4'd8) ? 4'd0 : cur_pat + 4'd1;
      end
    end else if (state_q == RECV) begin
      len_err_d = 1'b1;
      state_d   = IDLE;
      beat_d    = '0;
      pat_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      pat_q       <= '0;
      prev_link_q <= '0;
      pkt_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      err_cnt_q   <= '0;
      short_cnt_q <= '0;
      tog_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pat_q       <= pat_d;
      prev_link_q <= link;
      pkt_done_q  <= pkt_done_d;
      len_err_q   <= len_err_d;
      seq_err_q   <= seq_err_d;
      cyc_cnt_q   <= sat_add(cyc_cnt_q, CNT_W'(1));
      tog_cnt_q   <= sat_add(tog_cnt_q, CNT_W'(popcount(link ^ prev_link_q)));
      if (accept)     flit_cnt_q  <= sat_add(flit_cnt_q, CNT_W'(1));
      if (pkt_done_d) pkt_cnt_q   <= sat_add(pkt_cnt_q, CNT_W'(1));
      if (seq_err_d)  err_cnt_q   <= sat_add(err_cnt_q, CNT_W'(1));
      if (len_err_d)  short_cnt_q <= sat_add(short_cnt_q, CNT_W'(1));
    end
  end

  assign pkt_done     = pkt_done_q;
  assign len_err      = len_err_q;
  assign seq_err      = seq_err_q;
  assign busy         = (state_q == RECV);
  assign pkt_count    = pkt_cnt_q;
  assign flit_count   = flit_cnt_q;
  assign err_count    = err_cnt_q;
  assign short_count  = short_cnt_q;
  assign toggle_count = tog_cnt_q;
  assign cycle_count  = cyc_cnt_q;

endmodule

// File: tb/tb_flit_rx_monitor.sv
// Self-checking bench for flit_rx_monitor: directed scenarios plus random bursts,
// compared every cycle against a packet-level reference model.
module tb_flit_rx_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flit_valid;
  logic [8:0]  input1, input2;
  logic        pkt_done, len_err, seq_err, busy;
  logic [31:0] pkt_count, flit_count, err_count, short_count, toggle_count, cycle_count;

  flit_rx_monitor #(.N(9), .PAYLOAD(20), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .input1(input1), .input2(input2),
    .pkt_done(pkt_done), .len_err(len_err), .seq_err(seq_err), .busy(busy),
    .pkt_count(pkt_count), .flit_count(flit_count), .err_count(err_count),
    .short_count(short_count), .toggle_count(toggle_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] PAT [9] = '{18'h3FC00, 18'h3FFFC, 18'h00FFF, 18'h0000F, 18'h3C000,
                                      18'h3FFC0, 18'h0FFFF, 18'h000FF, 18'h00000};

  int          n_checks = 0;
  int          n_miss   = 0;
  // Reference model: packet length so far plus running totals.
  int unsigned m_pkt, m_flit, m_err, m_short, m_tog, m_cyc;
  int          m_len;
  logic [17:0] m_prev, cur_link;
  bit          e_done, e_len, e_seq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit v, input logic [17:0] l);
    e_done = 0; e_len = 0; e_seq = 0;
    if (r) begin
      m_pkt = 0; m_flit = 0; m_err = 0; m_short = 0; m_tog = 0; m_cyc = 0;
      m_len = 0; m_prev = '0;
    end else begin
      m_cyc++;
      m_tog += $countones(l ^ m_prev);
      m_prev = l;
      if (v) begin
        m_flit++;
        if (l != PAT[m_len % 9]) begin m_err++; e_seq = 1; end
        m_len++;
        if (m_len == 20) begin m_pkt++; e_done = 1; m_len = 0; end
      end else if (m_len > 0) begin
        m_short++; e_len = 1; m_len = 0;
      end
    end
  endtask

  // One clock: drive on the falling edge, check 1 ns after the rising edge.
  task automatic step(input bit r, input bit v, input logic [17:0] l);
    @(negedge clk);
    rst = r; flit_valid = v; {input2, input1} = l; cur_link = l;
    @(posedge clk);
    model_update(r, v, l);
    #1;
    check("pkt_done",     32'(pkt_done), 32'(e_done));
    check("len_err",      32'(len_err),  32'(e_len));
    check("seq_err",      32'(seq_err),  32'(e_seq));
    check("busy",         32'(busy),     32'(m_len > 0));
    check("pkt_count",    pkt_count,     m_pkt);
    check("flit_count",   flit_count,    m_flit);
    check("err_count",    err_count,     m_err);
    check("short_count",  short_count,   m_short);
    check("toggle_count", toggle_count,  m_tog);
    check("cycle_count",  cycle_count,   m_cyc);
  endtask

  task automatic send_pkt(input int n, input int bad_beat);
    for (int i = 0; i < n; i++) step(0, 1, (i == bad_beat) ? 18'h0 : PAT[i % 9]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, cur_link);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 18'($urandom));
    step(0, 0, 18'h0);
  endtask

  initial begin
    rst = 1'b1; flit_valid = 1'b0; input1 = '0; input2 = '0; cur_link = '0;
    model_update(1, 0, '0);

    // Reset with random link, then idle at zero.
    for (int i = 0; i < 3; i++) step(1, 0, 18'($urandom));
    for (int i = 0; i < 5; i++) step(0, 0, 18'h0);
    check("idle_cycles",  cycle_count,  32'd5);
    check("idle_toggles", toggle_count, 32'd0);

    // Single clean packet.
    send_pkt(20, -1);
    idle(7);
    check("one_pkt",     pkt_count,    32'd1);
    check("one_flits",   flit_count,   32'd20);
    check("one_errs",    err_count,    32'd0);
    check("one_toggles", toggle_count, 32'd160);

    // Ten packets with gaps.
    do_reset();
    for (int p = 0; p < 10; p++) begin send_pkt(20, -1); idle(7); end
    check("ten_pkts",    pkt_count,    32'd10);
    check("ten_flits",   flit_count,   32'd200);
    check("ten_toggles", toggle_count, 32'd1600);
    check("ten_shorts",  short_count,  32'd0);

    // Short packet.
    do_reset();
    send_pkt(5, -1);
    idle(3);
    check("short_shorts", short_count, 32'd1);
    check("short_pkts",   pkt_count,   32'd0);
    check("short_flits",  flit_count,  32'd5);
    check("short_busy",   32'(busy),   32'd0);

    // Corrupted fourth flit.
    do_reset();
    send_pkt(20, 3);
    idle(3);
    check("corrupt_errs", err_count, 32'd1);
    check("corrupt_pkts", pkt_count, 32'd1);

    // Back-to-back packets, then reset mid-packet.
    do_reset();
    send_pkt(20, -1);
    send_pkt(20, -1);
    check("b2b_pkts", pkt_count, 32'd2);
    check("b2b_errs", err_count, 32'd0);
    send_pkt(10, -1);
    step(1, 0, cur_link);
    check("midrst_shorts", short_count, 32'd0);
    check("midrst_flits",  flit_count,  32'd0);
    check("midrst_busy",   32'(busy),   32'd0);

    // Random bursts with occasional bit flips and random gap traffic.
    do_reset();
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        logic [17:0] v;
        v = PAT[m_len % 9];
        if ($urandom_range(0, 15) == 0) v = v ^ (18'h1 << $urandom_range(0, 17));
        step(0, 1, v);
      end
      for (int g = $urandom_range(0, 4); g > 0; g--) step(0, 0, 18'($urandom));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
